// File: rtl/ysyx_23060075_axi_lite_master_pkg.sv
// Shared widths, AXI response codes and FSM encoding for the AXI-lite initiator.
// Kept in one package so the responder side and the bench agree on encodings.
package ysyx_23060075_axi_lite_master_pkg;

    localparam int ISA_WIDTH      = 32;
    localparam int MEM_MASK_WIDTH = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_WR   = 3'd3,
        ST_B    = 3'd4,
        ST_RESP = 3'd5
    } state_e;

    // Anything other than OKAY is reported to the CPU as an error, EXOKAY included.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/ysyx_23060075_axi_lite_master.sv
// AXI-lite initiator: one outstanding CPU request turned into an AR/R or AW/W/B transaction,
// with the result held on a valid/ready response port. Every AXI and response output is a flop.
module ysyx_23060075_axi_lite_master
    import ysyx_23060075_axi_lite_master_pkg::*;
#(
    parameter int ADDR_WIDTH = ISA_WIDTH,
    parameter int DATA_WIDTH = ISA_WIDTH,
    parameter int STRB_WIDTH = MEM_MASK_WIDTH,
    parameter int RESP_WIDTH = ISA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [STRB_WIDTH-1:0] req_wmask,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] axi_araddr,
    output logic                  axi_arvalid,
    input  logic                  axi_arready,
    input  logic [DATA_WIDTH-1:0] axi_rdata,
    input  logic [RESP_WIDTH-1:0] axi_rresp,
    input  logic                  axi_rvalid,
    output logic                  axi_rready,
    output logic [ADDR_WIDTH-1:0] axi_awaddr,
    output logic                  axi_awvalid,
    input  logic                  axi_awready,
    output logic [DATA_WIDTH-1:0] axi_wdata,
    output logic [STRB_WIDTH-1:0] axi_wstrb,
    output logic                  axi_wvalid,
    input  logic                  axi_wready,
    input  logic [RESP_WIDTH-1:0] axi_bresp,
    input  logic                  axi_bvalid,
    output logic                  axi_bready
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wmask_q, wmask_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;

    logic req_fire, ar_fire, r_fire, b_fire, resp_fire;
    logic aw_done_now, w_done_now;
    logic unused_resp_bits;

    assign req_ready   = (state_q == ST_IDLE);
    assign req_fire    = req_valid && req_ready;
    assign ar_fire     = arvalid_q && axi_arready;
    assign r_fire      = rready_q && axi_rvalid;
    assign b_fire      = bready_q && axi_bvalid;
    assign resp_fire   = resp_valid_q && resp_ready;
    // A channel counts as done in the cycle its handshake happens, so AW and W may finish together.
    assign aw_done_now = aw_done_q || (awvalid_q && axi_awready);
    assign w_done_now  = w_done_q || (wvalid_q && axi_wready);

    assign unused_resp_bits = ^{axi_rresp, axi_bresp};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            resp_valid_q <= resp_valid_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_fire) state_d = req_wen ? ST_WR : ST_AR;
            ST_AR:   if (ar_fire) state_d = ST_R;
            ST_R:    if (r_fire) state_d = ST_RESP;
            ST_WR:   if (aw_done_now && w_done_now) state_d = ST_B;
            ST_B:    if (b_fire) state_d = ST_RESP;
            ST_RESP: if (resp_fire) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead so every valid/ready leaves the block from a flop.
    always_comb begin
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        arvalid_d    = 1'b0;
        rready_d     = 1'b0;
        awvalid_d    = 1'b0;
        wvalid_d     = 1'b0;
        bready_d     = 1'b0;
        resp_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_fire) begin
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    wmask_d   = req_wmask;
                    arvalid_d = !req_wen;
                    awvalid_d = req_wen;
                    wvalid_d  = req_wen;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            ST_AR: begin
                arvalid_d = !axi_arready;
                rready_d  = axi_arready;
            end
            ST_R: begin
                if (axi_rvalid) begin
                    rdata_d      = axi_rdata;
                    err_d        = resp_is_err(axi_rresp[1:0]);
                    resp_valid_d = 1'b1;
                end else begin
                    rready_d = 1'b1;
                end
            end
            ST_WR: begin
                aw_done_d = aw_done_now;
                w_done_d  = w_done_now;
                awvalid_d = !aw_done_now;
                wvalid_d  = !w_done_now;
                bready_d  = aw_done_now && w_done_now;
            end
            ST_B: begin
                if (axi_bvalid) begin
                    rdata_d      = '0;
                    err_d        = resp_is_err(axi_bresp[1:0]);
                    resp_valid_d = 1'b1;
                end else begin
                    bready_d = 1'b1;
                end
            end
            ST_RESP: resp_valid_d = !resp_ready;
            default: ;
        endcase
    end

    assign axi_araddr  = addr_q;
    assign axi_arvalid = arvalid_q;
    assign axi_rready  = rready_q;
    assign axi_awaddr  = addr_q;
    assign axi_awvalid = awvalid_q;
    assign axi_wdata   = wdata_q;
    assign axi_wstrb   = wmask_q;
    assign axi_wvalid  = wvalid_q;
    assign axi_bready  = bready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = rdata_q;
    assign resp_err    = err_q;

endmodule

// File: tb/tb_ysyx_23060075_axi_lite_master.sv
// Bench for the AXI-lite initiator: a word-array responder with random or scripted
// per-channel latency, and a reference memory that predicts every response.
module tb_ysyx_23060075_axi_lite_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid, req_ready, req_wen;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wmask;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] axi_araddr, axi_rdata, axi_rresp, axi_awaddr, axi_wdata, axi_bresp;
    logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
    logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
    logic [3:0]  axi_wstrb;

    int n_cmp = 0;
    int n_mis = 0;

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];

    bit         scripted = 1'b0;
    int         ar_lat, r_lat, aw_lat, w_lat, b_lat;
    logic [1:0] rresp_force = 2'b00;
    logic [1:0] bresp_force = 2'b00;

    bit          ar_arm, aw_arm, w_arm, r_pend, b_pend, aw_got, w_got;
    int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    logic [5:0]  rd_idx, wr_idx;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    bit          ar_hs, r_hs, aw_hs, w_hs, b_hs;
    bit          aw_seen, w_seen, newly_done;
    int          b_count = 0;

    always #5 clk = ~clk;

    ysyx_23060075_axi_lite_master dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int lat);
        return scripted ? lat : int'($urandom_range(0, 4));
    endfunction

    // Responder and protocol monitor both run on the falling edge; *_hs flags hold the
    // handshakes that the rising edge in between is going to see.
    always @(negedge clk) begin
        if (rst) begin
            axi_arready = 1'b0; axi_rvalid = 1'b0; axi_awready = 1'b0;
            axi_wready  = 1'b0; axi_bvalid = 1'b0;
            {ar_arm, aw_arm, w_arm, r_pend, b_pend, aw_got, w_got, aw_seen, w_seen} = '0;
        end else begin
            if (ar_hs) begin
                axi_arready = 1'b0; ar_arm = 1'b0; r_pend = 1'b1; r_cnt = pick(r_lat);
            end else if (axi_arvalid && !axi_arready) begin
                if (!ar_arm) begin ar_cnt = pick(ar_lat); ar_arm = 1'b1; end
                if (ar_cnt == 0) begin axi_arready = 1'b1; rd_idx = axi_araddr[7:2]; end
                else ar_cnt--;
            end
            if (r_hs) axi_rvalid = 1'b0;
            else if (r_pend) begin
                if (r_cnt == 0) begin
                    axi_rvalid = 1'b1; axi_rdata = mem[rd_idx];
                    axi_rresp = {30'($urandom), rresp_force}; r_pend = 1'b0;
                end else r_cnt--;
            end
            if (aw_hs) begin
                axi_awready = 1'b0; aw_arm = 1'b0; aw_got = 1'b1;
            end else if (axi_awvalid && !axi_awready) begin
                if (!aw_arm) begin aw_cnt = pick(aw_lat); aw_arm = 1'b1; end
                if (aw_cnt == 0) begin axi_awready = 1'b1; wr_idx = axi_awaddr[7:2]; end
                else aw_cnt--;
            end
            if (w_hs) begin
                axi_wready = 1'b0; w_arm = 1'b0; w_got = 1'b1;
            end else if (axi_wvalid && !axi_wready) begin
                if (!w_arm) begin w_cnt = pick(w_lat); w_arm = 1'b1; end
                if (w_cnt == 0) begin axi_wready = 1'b1; wr_data = axi_wdata; wr_strb = axi_wstrb; end
                else w_cnt--;
            end
            if (aw_got && w_got) begin
                for (int i = 0; i < 4; i++)
                    if (wr_strb[i]) mem[wr_idx][8*i +: 8] = wr_data[8*i +: 8];
                aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b1; b_cnt = pick(b_lat);
            end
            if (b_hs) axi_bvalid = 1'b0;
            else if (b_pend) begin
                if (b_cnt == 0) begin
                    axi_bvalid = 1'b1; axi_bresp = {30'($urandom), bresp_force}; b_pend = 1'b0;
                end else b_cnt--;
            end

            newly_done = !(aw_seen && w_seen) && (aw_seen || aw_hs) && (w_seen || w_hs);
            aw_seen = aw_seen || aw_hs;
            w_seen  = w_seen || w_hs;
            if (aw_seen) chk("awvalid_after_aw_hs", 32'(axi_awvalid), 32'd0);
            if (w_seen) chk("wvalid_after_w_hs", 32'(axi_wvalid), 32'd0);
            if (newly_done) chk("bready_cycle_after_aw_w", 32'(axi_bready), 32'd1);
            if (axi_bready) chk("bready_needs_aw_and_w", 32'(aw_seen && w_seen), 32'd1);
            if (b_hs) begin aw_seen = 1'b0; w_seen = 1'b0; end
        end
        ar_hs = axi_arvalid && axi_arready;
        r_hs  = axi_rvalid && axi_rready;
        aw_hs = axi_awvalid && axi_awready;
        w_hs  = axi_wvalid && axi_wready;
        b_hs  = axi_bvalid && axi_bready;
        b_count += int'(b_hs);
    end

    task automatic do_req(input logic wen, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m, input int hold);
        logic [31:0] exp_d, cur;
        logic        exp_e;
        int          n, b0;
        b0  = b_count;
        cur = ref_mem[a[7:2]];
        if (wen) begin
            for (int i = 0; i < 4; i++) if (m[i]) cur[8*i +: 8] = d[8*i +: 8];
            ref_mem[a[7:2]] = cur;
            exp_d = 32'd0;
            exp_e = (bresp_force != 2'b00);
        end else begin
            exp_d = cur;
            exp_e = (rresp_force != 2'b00);
        end
        req_valid = 1'b1; req_wen = wen; req_addr = a; req_wdata = d; req_wmask = m;
        @(negedge clk);
        req_valid = 1'b0;
        chk("req_ready_busy", 32'(req_ready), 32'd0);
        if (wen) begin
            chk("aw_w_issue", 32'({axi_awvalid, axi_wvalid, axi_arvalid}), 32'b110);
            chk("awaddr", axi_awaddr, a);
            chk("wdata", axi_wdata, d);
            chk("wstrb", 32'(axi_wstrb), 32'(m));
        end else begin
            chk("ar_issue", 32'({axi_arvalid, axi_awvalid, axi_wvalid}), 32'b100);
            chk("araddr", axi_araddr, a);
        end
        n = 0;
        while (!resp_valid && n < 100) begin @(negedge clk); n++; end
        chk("resp_within_bound", 32'(resp_valid), 32'd1);
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1; req_wen = 1'($urandom_range(0, 1)); req_addr = a ^ 32'h40;
            @(negedge clk);
            chk("hold_resp_valid", 32'(resp_valid), 32'd1);
            chk("hold_rdata", resp_rdata, exp_d);
            chk("hold_err", 32'(resp_err), 32'(exp_e));
            chk("hold_no_accept", 32'({req_ready, axi_arvalid, axi_awvalid}), 32'd0);
            chk("hold_addr_kept", axi_araddr, a);
        end
        chk("resp_rdata", resp_rdata, exp_d);
        chk("resp_err", 32'(resp_err), 32'(exp_e));
        chk("b_handshakes", 32'(b_count - b0), 32'(wen));
        req_valid = 1'b0; resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("resp_done_idle", 32'({resp_valid, req_ready}), 32'b01);
    endtask

    initial begin
        int n;
        req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
        resp_ready = 1'b0;
        axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rdata = '0; axi_rresp = '0;
        axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bresp = '0;
        ar_lat = 0; r_lat = 0; aw_lat = 0; w_lat = 0; b_lat = 0;
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[0] = 32'hDEADBEEF; ref_mem[0] = 32'hDEADBEEF;

        repeat (3) @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_valids", 32'({axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready, resp_valid}), 32'd0);
        chk("reset_resp_err", 32'(resp_err), 32'd0);
        chk("reset_rdata", resp_rdata, 32'd0);
        chk("reset_addr", axi_araddr, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Plain read against the random-latency memory.
        do_req(1'b0, 32'h8000_0000, 32'd0, 4'd0, 0);

        // AW accepted at once, W held off three cycles; then read the half-word update back.
        scripted = 1'b1; aw_lat = 0; w_lat = 3; b_lat = 1;
        do_req(1'b1, 32'h8000_0010, 32'h1234_5678, 4'b0011, 0);
        scripted = 1'b0;
        do_req(1'b0, 32'h8000_0010, 32'd0, 4'd0, 0);
        chk("readback_low_half", 32'(resp_rdata[15:0]), 32'h5678);

        // AW and W handshake in the same cycle.
        scripted = 1'b1; aw_lat = 1; w_lat = 1; b_lat = 0;
        do_req(1'b1, 32'h8000_0024, 32'hA5A5_0F0F, 4'b1111, 0);

        // Error responses on both paths; read data still delivered.
        scripted = 1'b0;
        bresp_force = 2'b10;
        do_req(1'b1, 32'h8000_0030, 32'hCAFE_F00D, 4'b1010, 0);
        bresp_force = 2'b00; rresp_force = 2'b11;
        do_req(1'b0, 32'h8000_0030, 32'd0, 4'd0, 0);
        rresp_force = 2'b00;

        // Consumer stalls four cycles while another request is pressed.
        do_req(1'b0, 32'h8000_0024, 32'd0, 4'd0, 4);

        // Reset while waiting for read data.
        scripted = 1'b1; ar_lat = 0; r_lat = 15;
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0020;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!axi_rready && n < 20) begin @(negedge clk); n++; end
        chk("reached_r_state", 32'({axi_rready, axi_arvalid}), 32'b10);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valids", 32'({axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready, resp_valid}), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        scripted = 1'b0;
        do_req(1'b0, 32'h8000_0020, 32'd0, 4'd0, 0);

        // Random mix of reads and writes with random latency, stalls and error codes.
        for (int t = 0; t < 40; t++) begin
            rresp_force = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            bresp_force = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            do_req(1'($urandom_range(0, 1)), 32'h8000_0000 | {24'd0, 6'($urandom_range(0, 63)), 2'b00},
                   $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
